// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the digit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of digit steps per operation; guards against a zero digit size.
  function automatic int ndig(input int width, input int digit);
    if (digit > 0) begin
      return width / digit;
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/full_sub_cell.sv
// Single-bit full subtractor: x - y - bi -> {bo, d}.
module full_sub_cell (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/sub_digit.sv
// Combinational DIGIT-bit ripple-borrow subtractor built from full_sub_cell.
module sub_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             bi,
  output logic [DIGIT-1:0] d,
  output logic             bo
);

  logic [DIGIT:0] w_b;

  assign w_b[0] = bi;

  for (genvar i = 0; i < DIGIT; i++) begin : g_cell
    full_sub_cell u_cell (
      .x  (x[i]),
      .y  (y[i]),
      .bi (w_b[i]),
      .d  (d[i]),
      .bo (w_b[i+1])
    );
  end

  assign bo = w_b[DIGIT];

endmodule

// File: rtl/serial_sub.sv
// Digit-serial subtractor: a - b - bin over WIDTH bits, DIGIT bits per clock,
// least-significant digit first, with a start/done handshake.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int             NDIG     = ndig(WIDTH, DIGIT);
  localparam int             CW       = $clog2(NDIG + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(NDIG - 1);

  if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_param_check
    $error("serial_sub: WIDTH must be >= 1 and a multiple of DIGIT, with 1 <= DIGIT <= WIDTH");
  end

  state_t           r_state;
  state_t           w_state_n;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_diff_sh;
  logic [WIDTH-1:0] w_diff_nx;
  logic             r_brw;
  logic             w_brw_n;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [DIGIT-1:0] w_d;

  sub_digit #(.DIGIT(DIGIT)) u_digit (
    .x  (r_a_sh[DIGIT-1:0]),
    .y  (r_b_sh[DIGIT-1:0]),
    .bi (r_brw),
    .d  (w_d),
    .bo (w_brw_n)
  );

  // New digit enters at the top as the result register shifts right.
  always_comb begin
    w_diff_nx                    = r_diff_sh >> DIGIT;
    w_diff_nx[WIDTH-1 -: DIGIT]  = w_d;
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_n = RUN;
        end else begin
          w_state_n = IDLE;
        end
      end
      RUN: begin
        if (r_cnt == CNT_LAST) begin
          w_state_n = DONE;
        end else begin
          w_state_n = RUN;
        end
      end
      DONE:    w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_busy  <= (w_state_n == RUN);
      r_done  <= (w_state_n == DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sh    <= {WIDTH{1'b0}};
      r_b_sh    <= {WIDTH{1'b0}};
      r_diff_sh <= {WIDTH{1'b0}};
      r_brw     <= 1'b0;
      r_cnt     <= {CW{1'b0}};
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a_sh <= a;
            r_b_sh <= b;
            r_brw  <= bin;
            r_cnt  <= {CW{1'b0}};
          end
        end
        RUN: begin
          r_a_sh    <= r_a_sh >> DIGIT;
          r_b_sh    <= r_b_sh >> DIGIT;
          r_diff_sh <= w_diff_nx;
          r_brw     <= w_brw_n;
          r_cnt     <= r_cnt + CW'(1);
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  assign diff = r_diff_sh;
  assign bout = r_brw;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: table vectors, scoreboard, corner sequences
// and a parameter sweep over (16,1), (16,16) and (8,2).
module tb_serial_sub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, bin, busy, done, bout;
  logic [15:0] a, b, diff;

  logic        s_start, sbin;
  logic [15:0] sa, sb;
  logic        busy_d1, done_d1, bout_d1, busy_d16, done_d16, bout_d16, busy_w8, done_w8, bout_w8;
  logic [15:0] diff_d1, diff_d16;
  logic [7:0]  diff_w8;

  serial_sub #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout));

  serial_sub #(.WIDTH(16), .DIGIT(1)) dut_d1 (
    .clk(clk), .rst(rst), .start(s_start), .a(sa), .b(sb), .bin(sbin),
    .busy(busy_d1), .done(done_d1), .diff(diff_d1), .bout(bout_d1));

  serial_sub #(.WIDTH(16), .DIGIT(16)) dut_d16 (
    .clk(clk), .rst(rst), .start(s_start), .a(sa), .b(sb), .bin(sbin),
    .busy(busy_d16), .done(done_d16), .diff(diff_d16), .bout(bout_d16));

  serial_sub #(.WIDTH(8), .DIGIT(2)) dut_w8 (
    .clk(clk), .rst(rst), .start(s_start), .a(sa[7:0]), .b(sb[7:0]), .bin(sbin),
    .busy(busy_w8), .done(done_w8), .diff(diff_w8), .bout(bout_w8));

  typedef struct {
    logic [15:0] diff;
    logic        bout;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] diff;
    logic        bout;
  } vec_t;

  exp_t sb_q[$];
  int   n_pass = 0, n_total = 0, n_done = 0, n_spur = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_total++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp_v, $time);
  endtask

  function automatic exp_t model16(input logic [15:0] x, input logic [15:0] y, input logic bi);
    logic [16:0] r;
    r = {1'b0, x} - {1'b0, y} - {16'd0, bi};
    model16.diff = r[15:0];
    model16.bout = r[16];
  endfunction

  // One cycle: sample after the falling edge, scoreboard any done pulse.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (done === 1'b1) begin
      n_done++;
      if (sb_q.size() == 0) begin
        n_spur++;
      end else begin
        e = sb_q.pop_front();
        chk("sb_diff", {16'd0, diff}, {16'd0, e.diff});
        chk("sb_bout", {31'd0, bout}, {31'd0, e.bout});
      end
    end
  endtask

  task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input logic ibin,
                        input exp_t e, input int poke);
    int lat, nbusy, d0;
    a = ia; b = ib; bin = ibin; start = 1'b1;
    sb_q.push_back(e);
    lat = -1; nbusy = 0; d0 = n_done;
    for (int j = 0; j < 20 && lat < 0; j++) begin
      tick();
      start = (poke != 0 && (j == 1 || j == 2)) ? 1'b1 : 1'b0;
      a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom_range(0, 1));
      if (busy) nbusy++;
      if (done) lat = j;
    end
    chk("latency", lat, 4);
    chk("busy_cycles", nbusy, 4);
    chk("done_count", n_done - d0, 1);
    start = 1'b0;
    tick();
  endtask

  task automatic sweep_op(input logic [15:0] ia, input logic [15:0] ib, input logic ibin);
    int l1, l16, l8;
    logic [15:0] d1, d16;
    logic [7:0]  d8;
    logic        b1, b16, b8;
    logic [8:0]  r8;
    exp_t        e;
    sa = ia; sb = ib; sbin = ibin; s_start = 1'b1;
    l1 = -1; l16 = -1; l8 = -1;
    d1 = '0; d16 = '0; d8 = '0; b1 = 1'b0; b16 = 1'b0; b8 = 1'b0;
    for (int j = 0; j < 24; j++) begin
      tick();
      s_start = 1'b0;
      sa = 16'($urandom); sb = 16'($urandom); sbin = 1'($urandom_range(0, 1));
      if (done_d1 && l1 < 0)   begin l1 = j;  d1 = diff_d1;   b1 = bout_d1;  end
      if (done_d16 && l16 < 0) begin l16 = j; d16 = diff_d16; b16 = bout_d16; end
      if (done_w8 && l8 < 0)   begin l8 = j;  d8 = diff_w8;   b8 = bout_w8;  end
    end
    e  = model16(ia, ib, ibin);
    r8 = {1'b0, ia[7:0]} - {1'b0, ib[7:0]} - {8'd0, ibin};
    chk("lat_16_1", l1, 16);
    chk("lat_16_16", l16, 1);
    chk("lat_8_2", l8, 4);
    chk("diff_16_1", {16'd0, d1}, {16'd0, e.diff});
    chk("bout_16_1", {31'd0, b1}, {31'd0, e.bout});
    chk("diff_16_16", {16'd0, d16}, {16'd0, e.diff});
    chk("bout_16_16", {31'd0, b16}, {31'd0, e.bout});
    chk("diff_8_2", {24'd0, d8}, {24'd0, r8[7:0]});
    chk("bout_8_2", {31'd0, b8}, {31'd0, r8[8]});
  endtask

  initial begin
    vec_t vt[8];
    vec_t hv[3];
    exp_t e;
    int   d0;
    int   dt[$];
    logic [15:0] ra, rb;
    logic        rbi;

    vt[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0};
    vt[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1};
    vt[2] = '{16'h8000, 16'h8000, 1'b1, 16'hFFFF, 1'b1};
    vt[3] = '{16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0};
    vt[4] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1};
    vt[5] = '{16'h5555, 16'hAAAA, 1'b0, 16'hAAAB, 1'b1};
    vt[6] = '{16'hAAAA, 16'h5555, 1'b1, 16'h5554, 1'b0};
    vt[7] = '{16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0};
    hv[0] = '{16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0};
    hv[1] = '{16'h0001, 16'h0002, 1'b0, 16'hFFFF, 1'b1};
    hv[2] = '{16'hABCD, 16'h1234, 1'b1, 16'h9998, 1'b0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    s_start = 1'b0; sa = '0; sb = '0; sbin = 1'b0;
    tick(); tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_diff", {16'd0, diff}, 32'd0);
    chk("rst_bout", {31'd0, bout}, 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      e.diff = vt[i].diff; e.bout = vt[i].bout;
      run_op(vt[i].a, vt[i].b, vt[i].bin, e, 0);
    end

    // start pulses during RUN are ignored; the result then holds while idle
    e.diff = 16'h00E1; e.bout = 1'b0;
    run_op(16'h00F0, 16'h000F, 1'b0, e, 1);
    d0 = n_done;
    repeat (10) tick();
    chk("hold_diff", {16'd0, diff}, 32'h0000_00E1);
    chk("hold_bout", {31'd0, bout}, 32'd0);
    chk("hold_no_done", n_done - d0, 0);

    // reset in the second RUN cycle discards the operation
    a = 16'h0000; b = 16'h0001; bin = 1'b1; start = 1'b1; d0 = n_done;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_diff", {16'd0, diff}, 32'd0);
    chk("midrst_bout", {31'd0, bout}, 32'd0);
    rst = 1'b0;
    repeat (6) tick();
    chk("midrst_no_done", n_done - d0, 0);
    e.diff = 16'h1000; e.bout = 1'b0;
    run_op(16'h1234, 16'h0234, 1'b0, e, 0);

    // start held high: three back-to-back operations
    a = hv[0].a; b = hv[0].b; bin = hv[0].bin; start = 1'b1;
    e.diff = hv[0].diff; e.bout = hv[0].bout; sb_q.push_back(e);
    for (int t = 0; t < 18; t++) begin
      tick();
      if (done) dt.push_back(t);
      if (t == 5)  begin a = hv[1].a; b = hv[1].b; bin = hv[1].bin;
                         e.diff = hv[1].diff; e.bout = hv[1].bout; sb_q.push_back(e); end
      if (t == 11) begin a = hv[2].a; b = hv[2].b; bin = hv[2].bin;
                         e.diff = hv[2].diff; e.bout = hv[2].bout; sb_q.push_back(e); end
      if (t == 12) start = 1'b0;
    end
    chk("held_done_count", dt.size(), 3);
    if (dt.size() == 3) begin
      chk("held_first", dt[0], 4);
      chk("held_gap1", dt[1] - dt[0], 6);
      chk("held_gap2", dt[2] - dt[1], 6);
    end

    for (int i = 0; i < 4; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rbi = 1'($urandom_range(0, 1));
      run_op(ra, rb, rbi, model16(ra, rb, rbi), 0);
    end

    sweep_op(16'h0000, 16'h0001, 1'b0);
    for (int i = 0; i < 3; i++) begin
      sweep_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    end

    chk("spurious_done", n_spur, 0);
    chk("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
